// File: rtl/timer_pkg.sv
// Shared definitions for the reload countdown timer.
// Provides the run-state enum, the direction encodings and a helper that
// gives the value a run finishes on for a given direction and latched N.
package timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  // Widest count the helper below supports; callers cast to their width.
  localparam int MAX_W = 64;

  // Down runs finish on zero, up runs finish on N.
  function automatic logic [MAX_W-1:0] terminal_of(input logic dir,
                                                   input logic [MAX_W-1:0] n);
    return (dir == DIR_UP) ? n : '0;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled clock cycles down to a single-cycle count tick.
// Ports:
//   clock   rising-edge clock
//   reset_n asynchronous active-low reset
//   en      advance the prescaler this cycle (frozen when low)
//   clr     force the prescaler back to zero (wins over en)
//   tick    combinational; high on the enabled cycle that completes DIV cycles
module tick_prescaler #(
  parameter int DIV = 1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // With DIV=1 the counter never leaves zero, so tick simply follows en.
  assign tick = en && (cnt == LAST);

  // Counter wraps on the tick and holds whenever en is low.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/reload_countdown_timer.sv
// Counts a latched terminal value N down to zero or up from zero at a
// prescaled tick rate, one-shot or auto-reloading, with pause and abort.
// Ports:
//   clock, reset_n     rising-edge clock, asynchronous active-low reset
//   load_value         N, sampled on an accepted start
//   start              begin/restart a run (ignored while stop is high)
//   stop               abort a run, count held
//   pause              freeze prescaler and count while running
//   direction          0 = down N->0, 1 = up 0->N (sampled on start)
//   auto_reload        1 = periodic, 0 = one-shot (sampled on start)
//   count              current count value
//   busy               high while running
//   done               one-cycle pulse on expiry
//   expire_count       expiries since last start, saturating
module reload_countdown_timer
  import timer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 1,
  parameter int EXP_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             direction,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [EXP_W-1:0] expire_count
);

  state_t           state, state_nx;
  logic [WIDTH-1:0] n_lat, n_nx;
  logic             dir_lat, dir_nx;
  logic             rel_lat, rel_nx;
  logic [WIDTH-1:0] count_nx;
  logic             done_nx;
  logic [EXP_W-1:0] exp_nx;

  logic             tick;
  logic             start_ok;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] term_val;
  logic [WIDTH-1:0] reload_val;

  assign start_ok   = start && !stop;
  assign busy       = (state == RUN);
  assign term_val   = WIDTH'(terminal_of(dir_lat, MAX_W'(n_lat)));
  assign reload_val = (dir_lat == DIR_DOWN) ? n_lat : '0;
  assign step_val   = (dir_lat == DIR_UP) ? count + WIDTH'(1) : count - WIDTH'(1);

  // Any start or stop restarts the prescaler so a new run gets a full first tick.
  tick_prescaler #(
    .DIV(DIV)
  ) u_prescaler (
    .clock  (clock),
    .reset_n(reset_n),
    .en     (busy && !pause),
    .clr    (stop || start_ok),
    .tick   (tick)
  );

  // Next-state logic. Priority is stop > start > terminal tick > ordinary tick,
  // so a start/stop landing on the terminal tick swallows that expiry.
  always_comb begin
    state_nx = state;
    count_nx = count;
    n_nx     = n_lat;
    dir_nx   = dir_lat;
    rel_nx   = rel_lat;
    done_nx  = 1'b0;
    exp_nx   = expire_count;

    if (stop) begin
      state_nx = IDLE;
    end else if (start) begin
      n_nx   = load_value;
      dir_nx = direction;
      rel_nx = auto_reload;
      exp_nx = '0;
      if (load_value == '0) begin
        // A zero-length run expires immediately and never enters RUN.
        done_nx  = 1'b1;
        exp_nx   = EXP_W'(1);
        state_nx = IDLE;
        count_nx = '0;
      end else begin
        state_nx = RUN;
        count_nx = (direction == DIR_DOWN) ? load_value : '0;
      end
    end else if (tick) begin
      if (step_val == term_val) begin
        done_nx = 1'b1;
        exp_nx  = (&expire_count) ? expire_count : expire_count + EXP_W'(1);
        if (rel_lat) begin
          // Periodic runs skip showing the terminal value to keep a period of N ticks.
          count_nx = reload_val;
        end else begin
          count_nx = term_val;
          state_nx = IDLE;
        end
      end else begin
        count_nx = step_val;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      count        <= '0;
      n_lat        <= '0;
      dir_lat      <= 1'b0;
      rel_lat      <= 1'b0;
      done         <= 1'b0;
      expire_count <= '0;
    end else begin
      state        <= state_nx;
      count        <= count_nx;
      n_lat        <= n_nx;
      dir_lat      <= dir_nx;
      rel_lat      <= rel_nx;
      done         <= done_nx;
      expire_count <= exp_nx;
    end
  end

endmodule

// File: tb/tb_reload_countdown_timer.sv
// Self-checking bench for reload_countdown_timer. Two instances (DIV=1 and
// DIV=4) share the same stimulus; each is compared every cycle against its
// own behavioural model, and the DIV=1 instance is also held to fixed
// expected values in the vector table and hand-written sequences.
module tb_reload_countdown_timer;

  localparam int DIV_FAST = 1;
  localparam int DIV_SLOW = 4;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] load_value;
  logic       start, stop, pause, direction, auto_reload;

  logic [7:0] count_f, count_s;
  logic       busy_f, busy_s, done_f, done_s;
  logic [7:0] exp_f, exp_s;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  reload_countdown_timer #(.WIDTH(8), .DIV(DIV_FAST), .EXP_W(8)) u_dut_fast (
    .clock(clock), .reset_n(reset_n), .load_value(load_value), .start(start),
    .stop(stop), .pause(pause), .direction(direction), .auto_reload(auto_reload),
    .count(count_f), .busy(busy_f), .done(done_f), .expire_count(exp_f)
  );

  reload_countdown_timer #(.WIDTH(8), .DIV(DIV_SLOW), .EXP_W(8)) u_dut_slow (
    .clock(clock), .reset_n(reset_n), .load_value(load_value), .start(start),
    .stop(stop), .pause(pause), .direction(direction), .auto_reload(auto_reload),
    .count(count_s), .busy(busy_s), .done(done_s), .expire_count(exp_s)
  );

  // Behavioural model: a run is "elapsed ticks out of N"; the displayed count
  // is derived from that, and cycles within a tick are counted separately.
  int div_of[2];
  int m_run[2], m_pre[2], m_elapsed[2], m_n[2], m_dir[2], m_rel[2];
  int m_cnt[2], m_done[2], m_exp[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_run[k] = 0; m_pre[k] = 0; m_elapsed[k] = 0; m_n[k] = 0;
      m_dir[k] = 0; m_rel[k] = 0; m_cnt[k] = 0; m_done[k] = 0; m_exp[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input logic st, input logic sp,
                            input logic pa, input logic dr, input logic rl,
                            input int ld);
    m_done[k] = 0;
    if (sp) begin
      if (m_run[k] != 0) begin
        m_run[k] = 0;
        m_pre[k] = 0;
      end
    end else if (st) begin
      m_n[k] = ld; m_dir[k] = dr; m_rel[k] = rl;
      m_pre[k] = 0; m_exp[k] = 0; m_elapsed[k] = 0;
      if (ld == 0) begin
        m_done[k] = 1; m_exp[k] = 1; m_run[k] = 0; m_cnt[k] = 0;
      end else begin
        m_run[k] = 1;
        m_cnt[k] = (dr != 0) ? 0 : ld;
      end
    end else if (m_run[k] != 0 && !pa) begin
      if (m_pre[k] == div_of[k] - 1) begin
        m_pre[k] = 0;
        m_elapsed[k]++;
        if (m_elapsed[k] == m_n[k]) begin
          m_done[k] = 1;
          if (m_exp[k] < 255) m_exp[k]++;
          if (m_rel[k] != 0) begin
            m_elapsed[k] = 0;
            m_cnt[k] = (m_dir[k] != 0) ? 0 : m_n[k];
          end else begin
            m_run[k] = 0;
            m_cnt[k] = (m_dir[k] != 0) ? m_n[k] : 0;
          end
        end else begin
          m_cnt[k] = (m_dir[k] != 0) ? m_elapsed[k] : m_n[k] - m_elapsed[k];
        end
      end else begin
        m_pre[k]++;
      end
    end
  endtask

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_errors++;
      $display("[TB] FAIL %s: actual=%0d required=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic check_output();
    check("fast.count",  int'(count_f), m_cnt[0]);
    check("fast.busy",   int'(busy_f),  m_run[0]);
    check("fast.done",   int'(done_f),  m_done[0]);
    check("fast.expire", int'(exp_f),   m_exp[0]);
    check("slow.count",  int'(count_s), m_cnt[1]);
    check("slow.busy",   int'(busy_s),  m_run[1]);
    check("slow.done",   int'(done_s),  m_done[1]);
    check("slow.expire", int'(exp_s),   m_exp[1]);
  endtask

  // Drive one cycle of inputs, let the edge happen, then step models and compare.
  task automatic apply_stimulus(input logic st, input logic sp, input logic pa,
                                input logic dr, input logic rl, input int ld);
    start = st; stop = sp; pause = pa; direction = dr; auto_reload = rl;
    load_value = 8'(ld);
    @(posedge clock);
    #1;
    model_step(0, st, sp, pa, dr, rl, ld);
    model_step(1, st, sp, pa, dr, rl, ld);
    check_output();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  typedef struct {
    logic st, sp, pa, dr, rl;
    int   ld;
    int   e_cnt;
    logic e_busy, e_done;
    int   e_exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic st, input logic sp, input logic pa,
                         input logic dr, input logic rl, input int ld,
                         input int e_cnt, input logic e_busy, input logic e_done,
                         input int e_exp);
    vec_t v;
    v.st = st; v.sp = sp; v.pa = pa; v.dr = dr; v.rl = rl; v.ld = ld;
    v.e_cnt = e_cnt; v.e_busy = e_busy; v.e_done = e_done; v.e_exp = e_exp;
    vecs.push_back(v);
  endtask

  initial begin
    div_of[0] = DIV_FAST;
    div_of[1] = DIV_SLOW;
    model_reset();
    reset_n = 1'b0;
    start = 1'b0; stop = 1'b0; pause = 1'b0; direction = 1'b0; auto_reload = 1'b0;
    load_value = 8'd0;

    #12;
    check_output();
    #1 reset_n = 1'b1;

    //       st sp pa dr rl ld   cnt busy done exp     (fast instance)
    // Down one-shot N=5
    add_vec(1, 0, 0, 0, 0, 5,    5, 1, 0, 0);
    add_vec(0, 0, 0, 0, 0, 0,    4, 1, 0, 0);
    add_vec(0, 0, 0, 0, 0, 0,    3, 1, 0, 0);
    add_vec(0, 0, 0, 0, 0, 0,    2, 1, 0, 0);
    add_vec(0, 0, 0, 0, 0, 0,    1, 1, 0, 0);
    add_vec(0, 0, 0, 0, 0, 0,    0, 0, 1, 1);
    add_vec(0, 0, 0, 0, 0, 0,    0, 0, 0, 1);
    // Start and stop together: stop wins
    add_vec(1, 1, 0, 0, 0, 7,    0, 0, 0, 1);
    // Restart on the terminal tick: no done, fresh run
    add_vec(1, 0, 0, 0, 1, 2,    2, 1, 0, 0);
    add_vec(0, 0, 0, 0, 0, 0,    1, 1, 0, 0);
    add_vec(1, 0, 0, 0, 0, 9,    9, 1, 0, 0);
    add_vec(0, 0, 0, 0, 0, 0,    8, 1, 0, 0);
    add_vec(0, 1, 0, 0, 0, 0,    8, 0, 0, 0);
    add_vec(0, 0, 0, 0, 0, 0,    8, 0, 0, 0);
    // Down auto-reload N=2
    add_vec(1, 0, 0, 0, 1, 2,    2, 1, 0, 0);
    add_vec(0, 0, 0, 0, 0, 0,    1, 1, 0, 0);
    add_vec(0, 0, 0, 0, 0, 0,    2, 1, 1, 1);
    add_vec(0, 0, 0, 0, 0, 0,    1, 1, 0, 1);
    add_vec(0, 0, 0, 0, 0, 0,    2, 1, 1, 2);
    add_vec(0, 1, 0, 0, 0, 0,    2, 0, 0, 2);
    // N=0 with reload: immediate expiry, stays idle
    add_vec(1, 0, 0, 0, 1, 0,    0, 0, 1, 1);
    add_vec(0, 0, 0, 0, 0, 0,    0, 0, 0, 1);
    add_vec(0, 0, 1, 0, 0, 0,    0, 0, 0, 1);
    // Up one-shot N=3
    add_vec(1, 0, 0, 1, 0, 3,    0, 1, 0, 0);
    add_vec(0, 0, 0, 0, 0, 0,    1, 1, 0, 0);
    add_vec(0, 0, 0, 0, 0, 0,    2, 1, 0, 0);
    add_vec(0, 0, 0, 0, 0, 0,    3, 0, 1, 1);
    add_vec(0, 0, 0, 0, 0, 0,    3, 0, 0, 1);
    // Up N=2 with pause and mid-run input changes ignored
    add_vec(1, 0, 0, 1, 0, 2,    0, 1, 0, 0);
    add_vec(0, 0, 1, 0, 0, 0,    0, 1, 0, 0);
    add_vec(0, 0, 0, 0, 0, 0,    1, 1, 0, 0);
    add_vec(0, 0, 0, 0, 1, 50,   2, 0, 1, 1);

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].st, vecs[i].sp, vecs[i].pa, vecs[i].dr, vecs[i].rl, vecs[i].ld);
      check($sformatf("vec%0d.count", i), int'(count_f), vecs[i].e_cnt);
      check($sformatf("vec%0d.busy", i),  int'(busy_f),  int'(vecs[i].e_busy));
      check($sformatf("vec%0d.done", i),  int'(done_f),  int'(vecs[i].e_done));
      check($sformatf("vec%0d.exp", i),   int'(exp_f),   vecs[i].e_exp);
    end

    // Pause at count 6 for 7 cycles, then stop at count 3
    apply_stimulus(1, 0, 0, 0, 0, 10);
    idle_cycles(4);
    check("pause.before", int'(count_f), 6);
    for (int i = 0; i < 7; i++) apply_stimulus(0, 0, 1, 0, 0, 0);
    check("pause.held", int'(count_f), 6);
    check("pause.busy", int'(busy_f), 1);
    idle_cycles(3);
    apply_stimulus(0, 1, 0, 0, 0, 0);
    check("stop.count", int'(count_f), 3);
    check("stop.busy",  int'(busy_f), 0);
    check("stop.done",  int'(done_f), 0);

    // Up auto-reload N=3: 300 expiries saturate the counter
    apply_stimulus(1, 0, 0, 1, 1, 3);
    idle_cycles(300 * 12);
    check("sat.slow", int'(exp_s), 255);
    check("sat.fast", int'(exp_f), 255);
    apply_stimulus(0, 1, 0, 0, 0, 0);

    // Up one-shot N=255 finishes on 255 without wrapping
    apply_stimulus(1, 0, 0, 1, 0, 255);
    idle_cycles(254);
    check("max.pre", int'(count_f), 254);
    idle_cycles(1);
    check("max.count", int'(count_f), 255);
    check("max.done",  int'(done_f), 1);
    check("max.busy",  int'(busy_f), 0);
    idle_cycles(1);
    check("max.hold",  int'(count_f), 255);
    apply_stimulus(0, 1, 0, 0, 0, 0);

    // Asynchronous reset between edges mid-run
    apply_stimulus(1, 0, 0, 0, 0, 9);
    idle_cycles(5);
    check("areset.before", int'(count_f), 4);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_output();
    check("areset.count", int'(count_f), 0);
    check("areset.busy",  int'(busy_f), 0);
    #1 reset_n = 1'b1;
    idle_cycles(3);

    // Randomised traffic against the model
    for (int i = 0; i < 2000; i++) begin
      logic st, sp, pa, dr, rl;
      int   ld;
      st = ($urandom_range(0, 99) < 6);
      sp = ($urandom_range(0, 99) < 3);
      pa = ($urandom_range(0, 99) < 20);
      dr = 1'($urandom_range(0, 1));
      rl = 1'($urandom_range(0, 1));
      ld = ($urandom_range(0, 19) == 0) ? 255 : int'($urandom_range(0, 12));
      apply_stimulus(st, sp, pa, dr, rl, ld);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
